// File: rtl/frequency_sweep_controller.sv
// Steps the lock-in reference frequency from start_freq to stop_freq, dwelling and measuring at each point.
// Optional SWEEP_LOOP_EN: restart at start_freq after the last point instead of stopping in DONE.
module frequency_sweep_controller #(
  parameter int FREQUENCY_RANGE = 8192,
  parameter int DWELL_W         = 24,
  localparam int W              = $clog2(FREQUENCY_RANGE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       manual_freq,
  input  logic [W-1:0]       start_freq,
  input  logic [W-1:0]       stop_freq,
  input  logic [W-1:0]       step,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic               start,
  input  logic               abort,
  input  logic               meas_valid,
  output logic [W-1:0]       freq_out,
  output logic               freq_update,
  output logic               meas_req,
  output logic [W-1:0]       point_index,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  typedef struct packed {
    logic [W-1:0]       start_f;
    logic [W-1:0]       stop_f;
    logic [W-1:0]       step_f;
    logic [DWELL_W-1:0] dwell;
    logic               up;
  } cfg_t;

  state_t             state;
  cfg_t               cfg;
  logic [DWELL_W-1:0] cnt;

  logic [W:0]   sum_up, diff_dn;
  logic [W-1:0] next_f;

  // One extra bit on both sides keeps the clamp correct near 0 and the top code.
  always_comb begin
    sum_up  = {1'b0, freq_out} + {1'b0, cfg.step_f};
    diff_dn = {1'b0, freq_out} - {1'b0, cfg.step_f};
    next_f  = cfg.stop_f;
    if (cfg.up) begin
      if (sum_up < {1'b0, cfg.stop_f}) next_f = sum_up[W-1:0];
    end else if (!diff_dn[W] && (diff_dn[W-1:0] > cfg.stop_f)) begin
      next_f = diff_dn[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cfg         <= '0;
      cnt         <= '0;
      freq_out    <= '0;
      freq_update <= 1'b0;
      meas_req    <= 1'b0;
      point_index <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      freq_update <= 1'b0;
      meas_req    <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        done     <= 1'b0;
        freq_out <= manual_freq;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (state == IDLE) freq_out <= manual_freq;
            if (start) begin
              cfg.start_f <= start_freq;
              cfg.stop_f  <= stop_freq;
              cfg.step_f  <= (step == '0) ? {{(W-1){1'b0}}, 1'b1} : step;
              cfg.dwell   <= dwell_cycles;
              cfg.up      <= (stop_freq >= start_freq);
              freq_out    <= start_freq;
              point_index <= '0;
              freq_update <= 1'b1;
              cnt         <= dwell_cycles;
              busy        <= 1'b1;
              done        <= 1'b0;
              state       <= SETTLE;
            end
          end
          SETTLE: begin
            if (cnt == '0) begin
              meas_req <= 1'b1;
              state    <= MEASURE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          MEASURE: begin
            if (meas_valid) begin
              if (freq_out == cfg.stop_f) begin
`ifdef SWEEP_LOOP_EN
                freq_out    <= cfg.start_f;
                point_index <= '0;
                freq_update <= 1'b1;
                cnt         <= cfg.dwell;
                state       <= SETTLE;
`else
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
`endif
              end else begin
                freq_out    <= next_f;
                point_index <= point_index + 1'b1;
                freq_update <= 1'b1;
                cnt         <= cfg.dwell;
                state       <= SETTLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
